du_pipe_reg_way0: RTL

DU_PIPE_REG_WAY0 -- requirements
Module: du_pipe_reg_way0

---
 rtl/du_pipe_reg_way0.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/du_pipe_reg_way0.sv
// Decode-to-execute pipeline register for way 0.
// Two-entry skid FIFO; ready_o comes from registered state only.
module du_pipe_reg_way0 #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [4:0]        rdAddr_i,
   input  logic              rdWriteEnable_i,
   input  logic [6:0]        opCode_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [5:0]        shamt_i,
   input  logic [1:0]        way0_pID_i,
   input  logic [DATA_W-1:0] rs1ReadData_i,
   input  logic [DATA_W-1:0] rs2ReadData_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic              jumpFlag_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [4:0]        rdAddr_o,
   output logic              rdWriteEnable_o,
   output logic [6:0]        opCode_o,
   output logic [2:0]        funct3_o,
   output logic [6:0]        funct7_o,
   output logic [5:0]        shamt_o,
   output logic [1:0]        way0_pID_o,
   output logic [DATA_W-1:0] rs1ReadData_o,
   output logic [DATA_W-1:0] rs2ReadData_o,
   output logic [DATA_W-1:0] imm_o,
   output logic [1:0]        count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [4:0]        rd_addr;
      logic              rd_we;
      logic [6:0]        op_code;
      logic [2:0]        funct3;
      logic [6:0]        funct7;
      logic [5:0]        shamt;
      logic [1:0]        pid;
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
      logic [DATA_W-1:0] imm;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   entry_t           mem [DEPTH];
   entry_t           in_e, head;
   logic             push, pop;

   assign ready_o = (state != FULL);
   assign valid_o = (state != EMPTY);
   assign push    = valid_i && ready_o && !jumpFlag_i;
   assign pop     = valid_o && ready_i && !jumpFlag_i;

   assign in_e = '{
      rd_addr: rdAddr_i,
      rd_we:   rdWriteEnable_i,
      op_code: opCode_i,
      funct3:  funct3_i,
      funct7:  funct7_i,
      shamt:   shamt_i,
      pid:     way0_pID_i,
      rs1:     rs1ReadData_i,
      rs2:     rs2ReadData_i,
      imm:     imm_i
   };

   always_comb begin
      state_n = state;
      if (jumpFlag_i) begin
         state_n = EMPTY;
      end else begin
         unique case (state)
            EMPTY: if (push) state_n = HALF;
            HALF: begin
               if (push && !pop)      state_n = FULL;
               else if (pop && !push) state_n = EMPTY;
            end
            FULL:    if (pop) state_n = HALF;
            default: state_n = EMPTY;
         endcase
      end
   end

   always_comb begin
      count_o = 2'd0;
      unique case (state)
         EMPTY:   count_o = 2'd0;
         HALF:    count_o = 2'd1;
         FULL:    count_o = 2'd2;
         default: count_o = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= state_n;
         // A flush realigns both pointers so the next push lands in entry 0.
         if (jumpFlag_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= in_e;
      end
   end

   assign head            = mem[rd_ptr];
   assign rdAddr_o        = head.rd_addr;
   assign rdWriteEnable_o = head.rd_we;
   assign opCode_o        = head.op_code;
   assign funct3_o        = head.funct3;
   assign funct7_o        = head.funct7;
   assign shamt_o         = head.shamt;
   assign way0_pID_o      = head.pid;
   assign rs1ReadData_o   = head.rs1;
   assign rs2ReadData_o   = head.rs2;
   assign imm_o           = head.imm;

endmodule
